// File: rtl/bank_arbiter_pkg.sv
// Shared definitions for the bank arbiter: requester indices and write-source encodings.
package bank_arbiter_pkg;

    localparam int N_REQ = 3;

    localparam int REQ_C = 0;
    localparam int REQ_D = 1;
    localparam int REQ_I = 2;

    typedef enum logic [1:0] {
        MUX_C = 2'd0,
        MUX_D = 2'd1,
        MUX_I = 2'd2
    } wr_mux_e;

    function automatic wr_mux_e req_to_mux(input int k);
        case (k)
            REQ_D:   return MUX_D;
            REQ_I:   return MUX_I;
            default: return MUX_C;
        endcase
    endfunction

endpackage

// File: rtl/bank_arbiter_rr_arb.sv
// Combinational round-robin picker: the search starts at ptr, wraps, and the first requester wins.
module rr_arb #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr_i) + off) % N;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = PW'((idx + 1) % N);
            end
        end
    end

endmodule

// File: rtl/bank_arbiter.sv
// Independent round-robin read/write arbitration for one BRAM bank shared by c, d and i requesters.
module bank_arbiter
    import bank_arbiter_pkg::*;
#(
    parameter int A = 9,
    parameter int N = N_REQ
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   rd_req,
    input  logic [N*A-1:0] rd_addr_in,
    output logic [N-1:0]   rd_gnt,
    output logic [N-1:0]   rd_vld,
    input  logic [N-1:0]   wr_req,
    input  logic [N*A-1:0] wr_addr_in,
    output logic [N-1:0]   wr_gnt,
    output logic           rd_en,
    output logic [A-1:0]   rd_addr,
    output logic           wr_en,
    output logic [A-1:0]   wr_addr,
    output logic [1:0]     wr_muxcode
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [N-1:0]  rd_gnt_raw, wr_gnt_raw;

    logic          rd_en_q, rd_en_d;
    logic [A-1:0]  rd_addr_q, rd_addr_d;
    logic          wr_en_q, wr_en_d;
    logic [A-1:0]  wr_addr_q, wr_addr_d;
    wr_mux_e       wr_mux_q, wr_mux_d;
    logic [N-1:0]  vld_p0_q, vld_p1_q;

    rr_arb #(.N(N), .PW(PW)) u_rd_arb (
        .req_i     (rd_req),
        .ptr_i     (rd_ptr_q),
        .gnt_o     (rd_gnt_raw),
        .ptr_nxt_o (rd_ptr_d)
    );

    rr_arb #(.N(N), .PW(PW)) u_wr_arb (
        .req_i     (wr_req),
        .ptr_i     (wr_ptr_q),
        .gnt_o     (wr_gnt_raw),
        .ptr_nxt_o (wr_ptr_d)
    );

    // Grants are suppressed during reset so nothing is handed out that the flush would discard.
    assign rd_gnt = rst ? '0 : rd_gnt_raw;
    assign wr_gnt = rst ? '0 : wr_gnt_raw;

    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_mux_d  = wr_mux_q;
        for (int k = 0; k < N; k++) begin
            if (rd_gnt_raw[k]) begin
                rd_en_d   = 1'b1;
                rd_addr_d = rd_addr_in[k*A +: A];
            end
            if (wr_gnt_raw[k]) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_addr_in[k*A +: A];
                wr_mux_d  = req_to_mux(k);
            end
        end
    end

    // Stage p0 aligns with the registered bank address, p1 with the BRAM data out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_mux_q  <= MUX_C;
            vld_p0_q  <= '0;
            vld_p1_q  <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_mux_q  <= wr_mux_d;
            vld_p0_q  <= rd_gnt_raw;
            vld_p1_q  <= vld_p0_q;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_muxcode = wr_mux_q;
    assign rd_vld     = vld_p1_q;

endmodule

// File: tb/tb_bank_arbiter.sv
// Scoreboard bench for bank_arbiter: reference round-robin model plus a queue of expected rd_vld words.
module tb_bank_arbiter;

    localparam int A = 9;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   rd_req, wr_req;
    logic [N*A-1:0] rd_addr_in, wr_addr_in;
    logic [N-1:0]   rd_gnt, wr_gnt, rd_vld;
    logic           rd_en, wr_en;
    logic [A-1:0]   rd_addr, wr_addr;
    logic [1:0]     wr_muxcode;

    bank_arbiter #(.A(A), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr_in (rd_addr_in),
        .rd_gnt     (rd_gnt),
        .rd_vld     (rd_vld),
        .wr_req     (wr_req),
        .wr_addr_in (wr_addr_in),
        .wr_gnt     (wr_gnt),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_muxcode (wr_muxcode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    int           m_rptr, m_wptr;
    logic         m_rd_en, m_wr_en;
    logic [A-1:0] m_rd_addr, m_wr_addr;
    logic [1:0]   m_mux;
    logic         started = 1'b0;
    logic [N-1:0] vq[$];
    logic [N-1:0] last_egr, last_egw;
    int           rwait[N];
    int           wwait[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req, input int ptr);
        for (int j = 0; j < N; j++) begin
            int k;
            k = (ptr + j) % N;
            if (req[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    task automatic tick();
        logic [N-1:0] egr, egw, vexp;
        @(negedge clk);
        egr = rst ? '0 : rr_pick(rd_req, m_rptr);
        egw = rst ? '0 : rr_pick(wr_req, m_wptr);
        chk("rd_gnt", 32'(rd_gnt), 32'(egr));
        chk("wr_gnt", 32'(wr_gnt), 32'(egw));
        chk("rd_onehot0", 32'($onehot0(rd_gnt)), 32'(1));
        chk("wr_onehot0", 32'($onehot0(wr_gnt)), 32'(1));
        if (started) begin
            chk("rd_en", 32'(rd_en), 32'(m_rd_en));
            chk("rd_addr", 32'(rd_addr), 32'(m_rd_addr));
            chk("wr_en", 32'(wr_en), 32'(m_wr_en));
            chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            chk("wr_muxcode", 32'(wr_muxcode), 32'(m_mux));
            chk("mux_not3", 32'(wr_muxcode != 2'd3), 32'(1));
        end
        vq.push_back(egr);
        if (vq.size() > 2) begin
            vexp = vq.pop_front();
            chk("rd_vld", 32'(rd_vld), 32'(vexp));
        end
        if (rst) foreach (vq[i]) vq[i] = '0;
        for (int k = 0; k < N; k++) begin
            if (!rst && rd_req[k] && !rd_gnt[k]) begin
                rwait[k]++;
                chk("rd_starve", 32'(rwait[k] <= N - 1), 32'(1));
            end else rwait[k] = 0;
            if (!rst && wr_req[k] && !wr_gnt[k]) begin
                wwait[k]++;
                chk("wr_starve", 32'(wwait[k] <= N - 1), 32'(1));
            end else wwait[k] = 0;
        end
        last_egr = egr;
        last_egw = egw;
        @(posedge clk);
        started = 1'b1;
        if (rst) begin
            m_rptr = 0; m_wptr = 0;
            m_rd_en = 1'b0; m_wr_en = 1'b0;
            m_rd_addr = '0; m_wr_addr = '0; m_mux = 2'd0;
        end else begin
            m_rd_en = |egr;
            m_wr_en = |egw;
            for (int k = 0; k < N; k++) begin
                if (egr[k]) begin
                    m_rd_addr = rd_addr_in[k*A +: A];
                    m_rptr = (k + 1) % N;
                end
                if (egw[k]) begin
                    m_wr_addr = wr_addr_in[k*A +: A];
                    m_mux = 2'(k);
                    m_wptr = (k + 1) % N;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_req = '0; wr_req = '0;
        rd_addr_in = '0; wr_addr_in = '0;
        m_rptr = 0; m_wptr = 0;
        m_rd_en = 1'b0; m_wr_en = 1'b0;
        m_rd_addr = '0; m_wr_addr = '0; m_mux = 2'd0;
        last_egr = '0; last_egw = '0;
        for (int k = 0; k < N; k++) begin rwait[k] = 0; wwait[k] = 0; end
        repeat (2) tick();
        rst = 1'b0;

        // all three readers held: c,d,i,c,d,i with rd_vld two cycles later
        rd_addr_in = {9'h1C2, 9'h0B1, 9'h0A0};
        rd_req = 3'b111;
        repeat (6) tick();
        rd_req = '0;
        repeat (3) tick();

        // DMA write
        wr_addr_in = {9'h000, 9'h1A5, 9'h000};
        wr_req = 3'b010;
        tick();
        wr_req = '0;
        repeat (2) tick();

        // same-address read and write from c in one cycle
        rd_addr_in = {9'h000, 9'h000, 9'h010};
        wr_addr_in = {9'h000, 9'h000, 9'h010};
        rd_req = 3'b001; wr_req = 3'b001;
        tick();
        rd_req = '0; wr_req = '0;
        repeat (2) tick();

        // read grant to i, then reset before its data returns
        rd_addr_in = {9'h155, 9'h000, 9'h000};
        rd_req = 3'b100;
        tick();
        rd_req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        rd_req = 3'b111; wr_req = 3'b011;
        tick();
        rd_req = '0; wr_req = '0;
        repeat (3) tick();

        // lone interconnect writer held for four cycles
        wr_addr_in = {9'h0F3, 9'h000, 9'h000};
        wr_req = 3'b100;
        repeat (4) tick();
        wr_req = '0;
        repeat (2) tick();

        // random held requests with occasional reset pulses
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(rd_req[k] && !last_egr[k])) begin
                    rd_req[k] = 1'($urandom_range(0, 1));
                    rd_addr_in[k*A +: A] = 9'($urandom);
                end
                if (!(wr_req[k] && !last_egw[k])) begin
                    wr_req[k] = 1'($urandom_range(0, 1));
                    wr_addr_in[k*A +: A] = 9'($urandom);
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        rd_req = '0; wr_req = '0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
